// File: rtl/hazard_pkg.sv
// Shared types and defaults for the EXE-stage forwarding and scoreboard logic.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

  // Source chosen for one operand port
  typedef enum logic [1:0] {
    FwdRf,
    FwdStage,
    FwdLong,
    FwdHaz
  } fwd_sel_e;

endpackage

// File: rtl/fwd_port_sel.sv
// Combinational operand resolution for a single read port: zero register,
// in-order forwarding stages, long-op completion bypass, then scoreboard.
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned REG_AW         = REG_AW_DEF
) (
  input  logic [REG_AW-1:0]                addr_i,
  input  logic [DATA_W-1:0]                rd_data_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_we_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_rdy_i,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_waddr_i,
  input  logic [NUM_FWD_STAGES*DATA_W-1:0] fwd_wdata_i,
  input  logic                             long_done_i,
  input  logic [REG_AW-1:0]                long_waddr_i,
  input  logic [DATA_W-1:0]                long_wdata_i,
  input  logic                             pend_hit_i,
  output logic [DATA_W-1:0]                data_o,
  output logic                             hazard_o
);

  fwd_sel_e          sel;
  logic [DATA_W-1:0] stage_data;
  logic              matched;

  always_comb begin
    sel        = FwdRf;
    stage_data = '0;
    matched    = (addr_i == '0);
    // Youngest matching stage wins; an unready match blocks older stages.
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      if (!matched && fwd_we_i[k] && (fwd_waddr_i[k*REG_AW +: REG_AW] == addr_i)) begin
        matched    = 1'b1;
        sel        = fwd_rdy_i[k] ? FwdStage : FwdHaz;
        stage_data = fwd_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    if (!matched) begin
      if (long_done_i && (long_waddr_i == addr_i)) begin
        sel = FwdLong;
      end else if (pend_hit_i) begin
        sel = FwdHaz;
      end
    end
  end

  always_comb begin
    data_o = rd_data_i;
    unique case (sel)
      FwdRf:    data_o = rd_data_i;
      FwdStage: data_o = stage_data;
      FwdLong:  data_o = long_wdata_i;
      FwdHaz:   data_o = rd_data_i;
    endcase
  end

  assign hazard_o = (sel == FwdHaz);

endmodule

// File: rtl/exe_fwd_scoreboard.sv
// EXE-stage RAW forwarding plus a scoreboard of outstanding long-latency writes.
// Define HAZARD_STATS_EN to add saturating stall-cause counters.
module exe_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned REG_AW         = REG_AW_DEF,
  parameter int unsigned MAX_PEND       = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_RD_PORTS*REG_AW-1:0]   rd_addr_i,
  input  logic [NUM_RD_PORTS*DATA_W-1:0]   rd_data_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_we_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_rdy_i,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_waddr_i,
  input  logic [NUM_FWD_STAGES*DATA_W-1:0] fwd_wdata_i,
  input  logic                             issue_valid_i,
  input  logic                             issue_long_i,
  input  logic [REG_AW-1:0]                issue_waddr_i,
  input  logic                             flush_i,
  input  logic                             long_done_i,
  input  logic [REG_AW-1:0]                long_waddr_i,
  input  logic [DATA_W-1:0]                long_wdata_i,
  output logic [NUM_RD_PORTS*DATA_W-1:0]   rdata_o,
  output logic                             stall_o,
  output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt_o,
`ifdef HAZARD_STATS_EN
  output logic [31:0]                      stall_raw_cnt_o,
  output logic [31:0]                      stall_long_cnt_o,
`endif
  output logic                             pend_full_o
);

  localparam int unsigned CntW    = $clog2(MAX_PEND+1);
  localparam int unsigned NumRegs = 2**REG_AW;

  logic [NumRegs-1:0]      pend_q, pend_d;
  logic [CntW-1:0]         pend_cnt_q, pend_cnt_d;
  logic [DATA_W-1:0]       port_data [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] port_haz;

  logic any_haz, waw, full, long_blk, stall, commit, done_clr;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .DATA_W        (DATA_W),
      .REG_AW        (REG_AW)
    ) u_sel (
      .addr_i      (rd_addr_i[p*REG_AW +: REG_AW]),
      .rd_data_i   (rd_data_i[p*DATA_W +: DATA_W]),
      .fwd_we_i    (fwd_we_i),
      .fwd_rdy_i   (fwd_rdy_i),
      .fwd_waddr_i (fwd_waddr_i),
      .fwd_wdata_i (fwd_wdata_i),
      .long_done_i (long_done_i),
      .long_waddr_i(long_waddr_i),
      .long_wdata_i(long_wdata_i),
      .pend_hit_i  (pend_q[rd_addr_i[p*REG_AW +: REG_AW]]),
      .data_o      (port_data[p]),
      .hazard_o    (port_haz[p])
    );
    assign rdata_o[p*DATA_W +: DATA_W] = rst_i ? '0 : port_data[p];
  end

  always_comb begin
    any_haz  = |port_haz;
    waw      = pend_q[issue_waddr_i] && !(long_done_i && (long_waddr_i == issue_waddr_i));
    full     = (pend_cnt_q == CntW'(MAX_PEND));
    long_blk = issue_long_i && (waw || (full && !long_done_i));
    stall    = issue_valid_i && !flush_i && (any_haz || long_blk);
    commit   = issue_valid_i && issue_long_i && !flush_i && !stall && (issue_waddr_i != '0);
    done_clr = long_done_i && pend_q[long_waddr_i];
  end

  // Set after clear so a same-register done and commit leaves the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (long_done_i) pend_d[long_waddr_i] = 1'b0;
    if (commit)      pend_d[issue_waddr_i] = 1'b1;
    pend_cnt_d = pend_cnt_q + CntW'(commit) - CntW'(done_clr);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign stall_o     = stall && !rst_i;
  assign pend_cnt_o  = pend_cnt_q;
  assign pend_full_o = full && !rst_i;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_raw_cnt_q, stall_long_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_raw_cnt_q  <= '0;
      stall_long_cnt_q <= '0;
    end else begin
      if (stall && any_haz && (stall_raw_cnt_q != '1)) begin
        stall_raw_cnt_q <= stall_raw_cnt_q + 32'd1;
      end
      if (stall && !any_haz && (stall_long_cnt_q != '1)) begin
        stall_long_cnt_q <= stall_long_cnt_q + 32'd1;
      end
    end
  end

  assign stall_raw_cnt_o  = stall_raw_cnt_q;
  assign stall_long_cnt_o = stall_long_cnt_q;
`endif

endmodule

// File: tb/tb_exe_fwd_scoreboard.sv
// Directed bench for exe_fwd_scoreboard with default parameters.
module tb_exe_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic [1:0]  fwd_we_i, fwd_rdy_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic        issue_valid_i, issue_long_i, flush_i, long_done_i;
  logic [4:0]  issue_waddr_i, long_waddr_i;
  logic [31:0] long_wdata_i;
  logic [63:0] rdata_o;
  logic        stall_o, pend_full_o;
  logic [2:0]  pend_cnt_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_raw_cnt_o, stall_long_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  exe_fwd_scoreboard dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_i    (rd_data_i),
    .fwd_we_i     (fwd_we_i),
    .fwd_rdy_i    (fwd_rdy_i),
    .fwd_waddr_i  (fwd_waddr_i),
    .fwd_wdata_i  (fwd_wdata_i),
    .issue_valid_i(issue_valid_i),
    .issue_long_i (issue_long_i),
    .issue_waddr_i(issue_waddr_i),
    .flush_i      (flush_i),
    .long_done_i  (long_done_i),
    .long_waddr_i (long_waddr_i),
    .long_wdata_i (long_wdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .pend_cnt_o   (pend_cnt_o),
`ifdef HAZARD_STATS_EN
    .stall_raw_cnt_o (stall_raw_cnt_o),
    .stall_long_cnt_o(stall_long_cnt_o),
`endif
    .pend_full_o  (pend_full_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rd_addr_i = '0; rd_data_i = '0;
    fwd_we_i = '0; fwd_rdy_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
    issue_valid_i = 1'b0; issue_long_i = 1'b0; issue_waddr_i = '0; flush_i = 1'b0;
    long_done_i = 1'b0; long_waddr_i = '0; long_wdata_i = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a, input logic [31:0] d);
    rd_addr_i[p*5 +: 5]  = a;
    rd_data_i[p*32 +: 32] = d;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic rdy,
                         input logic [4:0] a, input logic [31:0] d);
    fwd_we_i[k] = we;
    fwd_rdy_i[k] = rdy;
    fwd_waddr_i[k*5 +: 5]  = a;
    fwd_wdata_i[k*32 +: 32] = d;
  endtask

  task automatic set_issue(input logic v, input logic lng, input logic [4:0] a, input logic fl);
    issue_valid_i = v; issue_long_i = lng; issue_waddr_i = a; flush_i = fl;
  endtask

  task automatic set_done(input logic [4:0] a, input logic [31:0] d);
    long_done_i = 1'b1; long_waddr_i = a; long_wdata_i = d;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h1);
    set_rd(0, 5'd5, 32'h1111);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL reset_stall got %b exp 0", stall_o); end
    checks++; if (rdata_o[31:0] !== 32'h0) begin failures++;
      $display("FAIL reset_rdata got %h exp 0", rdata_o[31:0]); end
    checks++; if (pend_cnt_o !== 3'd0) begin failures++;
      $display("FAIL reset_cnt got %0d exp 0", pend_cnt_o); end
    checks++; if (pend_full_o !== 1'b0) begin failures++;
      $display("FAIL reset_full got %b exp 0", pend_full_o); end
    @(negedge clk);
    rst_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    clear_inputs();
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hAAAA);
    set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    set_rd(0, 5'd5, 32'h1111);
    set_rd(1, 5'd0, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (rdata_o[31:0] !== 32'hAAAA) begin failures++;
      $display("FAIL fwd_youngest got %h exp 0000aaaa", rdata_o[31:0]); end
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL fwd_nostall got %b exp 0", stall_o); end
    @(negedge clk);
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'h1234);
    set_fwd(1, 1'b1, 1'b1, 5'd6, 32'hBBBB);
    set_rd(0, 5'd6, 32'h2222);
    set_rd(1, 5'd0, 32'h0);
    #1;
    checks++; if (rdata_o[63:32] !== 32'h0) begin failures++;
      $display("FAIL fwd_r0 got %h exp 0", rdata_o[63:32]); end
    checks++; if (rdata_o[31:0] !== 32'hBBBB) begin failures++;
      $display("FAIL fwd_stage1 got %h exp 0000bbbb", rdata_o[31:0]); end
    @(negedge clk);
    set_fwd(0, 1'b0, 1'b1, 5'd6, 32'h1);
    set_fwd(1, 1'b0, 1'b1, 5'd6, 32'h2);
    #1;
    checks++; if (rdata_o[31:0] !== 32'h2222) begin failures++;
      $display("FAIL fwd_rf got %h exp 00002222", rdata_o[31:0]); end
  endtask

  task automatic test_load_hazard();
    @(negedge clk);
    clear_inputs();
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
    set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h55);
    set_rd(1, 5'd7, 32'h3333);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++;
      $display("FAIL load_stall got %b exp 1", stall_o); end
    issue_valid_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL load_noissue got %b exp 0", stall_o); end
    @(negedge clk);
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h99);
    issue_valid_i = 1'b1;
    #1;
    checks++; if (rdata_o[63:32] !== 32'h99) begin failures++;
      $display("FAIL load_ready got %h exp 00000099", rdata_o[63:32]); end
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL load_ready_stall got %b exp 0", stall_o); end
  endtask

  task automatic test_long_issue();
    @(negedge clk);
    clear_inputs();
    set_issue(1'b1, 1'b1, 5'd9, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL long_commit_stall got %b exp 0", stall_o); end
    @(negedge clk);
    clear_inputs();
    set_rd(0, 5'd9, 32'h4444);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++;
      $display("FAIL long_raw_stall got %b exp 1", stall_o); end
    checks++; if (pend_cnt_o !== 3'd1) begin failures++;
      $display("FAIL long_cnt1 got %0d exp 1", pend_cnt_o); end
    @(negedge clk);
    set_done(5'd9, 32'hCAFE);
    #1;
    checks++; if (rdata_o[31:0] !== 32'hCAFE) begin failures++;
      $display("FAIL long_bypass got %h exp 0000cafe", rdata_o[31:0]); end
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL long_bypass_stall got %b exp 0", stall_o); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pend_cnt_o !== 3'd0) begin failures++;
      $display("FAIL long_cnt0 got %0d exp 0", pend_cnt_o); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      clear_inputs();
      set_issue(1'b1, 1'b1, 5'(i), 1'b0);
      #1;
      checks++; if (stall_o !== 1'b0) begin failures++;
        $display("FAIL full_fill%0d got %b exp 0", i, stall_o); end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pend_cnt_o !== 3'd4) begin failures++;
      $display("FAIL full_cnt got %0d exp 4", pend_cnt_o); end
    checks++; if (pend_full_o !== 1'b1) begin failures++;
      $display("FAIL full_flag got %b exp 1", pend_full_o); end
    set_issue(1'b1, 1'b1, 5'd6, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++;
      $display("FAIL full_block got %b exp 1", stall_o); end
    @(negedge clk);
    set_issue(1'b1, 1'b1, 5'd6, 1'b0);
    set_done(5'd2, 32'h0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL full_done_commit got %b exp 0", stall_o); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pend_cnt_o !== 3'd4) begin failures++;
      $display("FAIL full_cnt_hold got %0d exp 4", pend_cnt_o); end
    checks++; if (pend_full_o !== 1'b1) begin failures++;
      $display("FAIL full_flag_hold got %b exp 1", pend_full_o); end
  endtask

  // Pending on entry: r1, r3, r4, r6.
  task automatic test_waw_reset();
    @(negedge clk);
    clear_inputs();
    set_done(5'd1, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pend_cnt_o !== 3'd3) begin failures++;
      $display("FAIL waw_cnt3 got %0d exp 3", pend_cnt_o); end
    set_issue(1'b1, 1'b1, 5'd3, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++;
      $display("FAIL waw_block got %b exp 1", stall_o); end
    @(negedge clk);
    set_done(5'd3, 32'h0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL waw_done_commit got %b exp 0", stall_o); end
    @(negedge clk);
    clear_inputs();
    set_rd(1, 5'd3, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++;
      $display("FAIL waw_still_pending got %b exp 1", stall_o); end
    checks++; if (pend_cnt_o !== 3'd3) begin failures++;
      $display("FAIL waw_cnt_hold got %0d exp 3", pend_cnt_o); end
    @(negedge clk);
    clear_inputs();
    set_done(5'd10, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (pend_cnt_o !== 3'd3) begin failures++;
      $display("FAIL done_nonpend got %0d exp 3", pend_cnt_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (pend_cnt_o !== 3'd0) begin failures++;
      $display("FAIL async_rst_cnt got %0d exp 0", pend_cnt_o); end
    @(negedge clk);
    rst_i = 1'b0;
    set_rd(0, 5'd6, 32'h0);
    set_rd(1, 5'd3, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL rst_bitmap_clear got %b exp 0", stall_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_inputs();
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
    set_rd(0, 5'd7, 32'h0);
    set_issue(1'b1, 1'b1, 5'd8, 1'b1);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL flush_stall got %b exp 0", stall_o); end
    @(negedge clk);
    clear_inputs();
    set_rd(0, 5'd8, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (pend_cnt_o !== 3'd0) begin failures++;
      $display("FAIL flush_cnt got %0d exp 0", pend_cnt_o); end
    checks++; if (stall_o !== 1'b0) begin failures++;
      $display("FAIL flush_no_pend got %b exp 0", stall_o); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    clear_inputs();
    rst_i = 1'b1;
    #1;
    checks++; if (stall_raw_cnt_o !== 32'd0 || stall_long_cnt_o !== 32'd0) begin failures++;
      $display("FAIL stats_reset got %0d/%0d exp 0/0", stall_raw_cnt_o, stall_long_cnt_o); end
    @(negedge clk);
    rst_i = 1'b0;
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
    set_rd(0, 5'd7, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_raw_cnt_o !== 32'd3) begin failures++;
      $display("FAIL stats_raw got %0d exp 3", stall_raw_cnt_o); end
    set_issue(1'b1, 1'b1, 5'd12, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_long_cnt_o !== 32'd1) begin failures++;
      $display("FAIL stats_long got %0d exp 1", stall_long_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_hazard();
    test_long_issue();
    test_full();
    test_waw_reset();
    test_flush();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
